// File: rtl/key_debounce.sv
// key_debounce: conditions one raw active-low mechanical key.
// The pin is brought into the clk domain through a two-flop synchroniser,
// then a four-state filter only accepts a new level after the synchronised
// key has been stable long enough. Accepted edges produce a clean level on
// po_key and a single-cycle po_press / po_release pulse.
module key_debounce #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pi_key,
    output logic       po_key,
    output logic       po_press,
    output logic       po_release,
    output logic [1:0] po_state
);

    // Filter states; po_state exposes the encoding directly for debug LEDs.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILT_DN = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] FILT_UP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // The counter must be able to reach the terminal count.
    if ((64'd1 << CNT_W) <= 64'(CNT_MAX)) begin : g_bad_width
        $error("key_debounce: CNT_W too small for CNT_MAX");
    end

    logic             key_m;
    logic             key_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; both stages reset to the released level so a
    // key held down through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            key_m <= pi_key;
            key_s <= key_m;
        end
    end

    // Debounce filter: a bounce back to the old level aborts the filter and
    // the count restarts from zero on the next attempt, so the stable time is
    // always measured from the last bounce. Pulses self-clear every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= CNT_ZERO;
            po_key     <= 1'b1;
            po_press   <= 1'b0;
            po_release <= 1'b0;
        end else begin
            po_press   <= 1'b0;
            po_release <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= CNT_ZERO;
                    if (!key_s) begin
                        state <= FILT_DN;
                    end
                end
                FILT_DN: begin
                    if (key_s) begin
                        state <= IDLE;
                        cnt   <= CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state    <= DOWN;
                        cnt      <= CNT_ZERO;
                        po_key   <= 1'b0;
                        po_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    cnt <= CNT_ZERO;
                    if (key_s) begin
                        state <= FILT_UP;
                    end
                end
                FILT_UP: begin
                    if (!key_s) begin
                        state <= DOWN;
                        cnt   <= CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE;
                        cnt        <= CNT_ZERO;
                        po_key     <= 1'b1;
                        po_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign po_state = state;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with a short filter (CNT_MAX=9).
// Reference model: the debounced level flips once a run of CNT_MAX+2
// consecutive clk samples differs from it (the first differing sample opens
// the filter, CNT_MAX+1 more confirm it); any sample equal to the level ends
// the run. Samples reach the filter two edges after capture.
module tb_key_debounce;

    localparam int CNT_MAX = 9;
    localparam int CNT_W   = 4;
    localparam int RUN_ACC = CNT_MAX + 2;

    logic       clk;
    logic       rst_n;
    logic       pi_key;
    logic       po_key;
    logic       po_press;
    logic       po_release;
    logic [1:0] po_state;

    int checks = 0;
    int errors = 0;

    // model state
    logic       e_key;
    logic       e_press;
    logic       e_release;
    logic [1:0] e_state;
    int         run;
    logic       d1, d2;

    key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pi_key     (pi_key),
        .po_key     (po_key),
        .po_press   (po_press),
        .po_release (po_release),
        .po_state   (po_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_key = 1'b1; e_press = 1'b0; e_release = 1'b0; e_state = 2'd0;
        run = 0; d1 = 1'b1; d2 = 1'b1;
    endtask

    function automatic logic [1:0] state_of(input logic lvl, input int r);
        if (lvl) return (r > 0) ? 2'd1 : 2'd0;
        else     return (r > 0) ? 2'd3 : 2'd2;
    endfunction

    task automatic model_edge(input logic v);
        logic x;
        x  = d2;
        d2 = d1;
        d1 = v;
        e_press   = 1'b0;
        e_release = 1'b0;
        if (x != e_key) begin
            run++;
            if (run == RUN_ACC) begin
                e_key = x;
                run   = 0;
                if (x == 1'b0) e_press = 1'b1;
                else           e_release = 1'b1;
            end
        end else begin
            run = 0;
        end
        e_state = state_of(e_key, run);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".key"},     {1'b0, po_key},     {1'b0, e_key});
        chk({tag, ".press"},   {1'b0, po_press},   {1'b0, e_press});
        chk({tag, ".release"}, {1'b0, po_release}, {1'b0, e_release});
        chk({tag, ".state"},   po_state,           e_state);
    endtask

    // Entered and left at a falling edge: drive, clock, predict, compare.
    task automatic cycle(input logic v, input string tag);
        pi_key = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic hold(input logic v, input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(v, tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        pi_key = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");

        // key held pressed through reset: press accepted after release
        rst_n = 1'b1;
        hold(1'b0, 30, "rst_press");

        // clean release then clean press/release
        hold(1'b1, 30, "clean_rel");
        hold(1'b0, 30, "clean_press");
        hold(1'b1, 30, "clean_rel2");

        // press bounce
        hold(1'b0, 5, "bounce");
        hold(1'b1, 3, "bounce");
        hold(1'b0, 4, "bounce");
        hold(1'b1, 2, "bounce");
        hold(1'b0, 30, "bounce_settle");

        // release bounce while down
        hold(1'b1, 6, "rel_bounce");
        hold(1'b0, 20, "rel_bounce");
        hold(1'b1, 30, "rel_settle");

        // acceptance boundary: runs around the acceptance length
        for (int n = RUN_ACC - 2; n <= RUN_ACC + 1; n++) begin
            hold(1'b0, n, "boundary");
            hold(1'b1, 30, "boundary_gap");
        end

        // asynchronous reset in the middle of the press filter
        hold(1'b0, 8, "pre_midrst");
        chk("midrst.state_before", po_state, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst_async");
        @(negedge clk);
        check_all("midrst_hold");
        rst_n = 1'b1;
        hold(1'b0, 20, "after_midrst");
        hold(1'b1, 20, "after_midrst_rel");

        // randomized bouncy segments
        for (int s = 0; s < 60; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom & 3) == 0) ? $urandom_range(12, 25) : $urandom_range(1, 12);
            hold(lvl, len, "random");
        end
        hold(1'b1, 30, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
